// File: rtl/display_pkg.sv
// Shared state encoding and constants for the time-shared BCD display converter.
package display_pkg;

    localparam int DIGIT_W   = 4;
    localparam int RADIX     = 10;
    localparam int NUM_PORTS = 3;

    // Which sevenseg instance shows each port's tens and units digit
    localparam int PORT0_HEX_TENS  = 0;
    localparam int PORT0_HEX_UNITS = 1;
    localparam int PORT1_HEX_TENS  = 4;
    localparam int PORT1_HEX_UNITS = 5;
    localparam int PORT2_HEX_TENS  = 2;
    localparam int PORT2_HEX_UNITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUB,
        STORE
    } seq_state_t;

endpackage

// File: rtl/bcd_div10_iter.sv
// Iterative divide-by-10: one subtraction of RADIX per step until the remainder drops below it.
module bcd_div10_iter
    import display_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [6:0]         load_val,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic               ge_radix
);

    logic [6:0] work;

    assign ge_radix = (work >= 7'(RADIX));
    assign units    = work[DIGIT_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            work <= '0;
            tens <= '0;
        end else if (load) begin
            work <= load_val;
            tens <= '0;
        end else if (step && ge_radix) begin
            work <= work - 7'(RADIX);
            tens <= tens + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/display_bcd_sequencer.sv
// Sequences the three CPU output ports through one shared divide-by-10 unit and
// holds the resulting two-digit decimal values for the sevenseg decoders.
module display_bcd_sequencer
    import display_pkg::*;
#(
    parameter int MAX_VAL   = 99,
    parameter int FRAME_GAP = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          out_port0,
    input  logic [31:0]          out_port1,
    input  logic [31:0]          out_port2,
    input  logic                 hold,
    output logic [DIGIT_W-1:0]   dig0_hi,
    output logic [DIGIT_W-1:0]   dig0_lo,
    output logic [DIGIT_W-1:0]   dig1_hi,
    output logic [DIGIT_W-1:0]   dig1_lo,
    output logic [DIGIT_W-1:0]   dig2_hi,
    output logic [DIGIT_W-1:0]   dig2_lo,
    output logic [NUM_PORTS-1:0] ovf,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

    seq_state_t         state;
    logic [1:0]         sel;
    logic [GAP_W-1:0]   gap_cnt;
    logic               ovf_next;
    logic [31:0]        port_val;
    logic               saturate;
    logic [6:0]         load_val;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
    logic               ge_radix;

    always_comb begin
        port_val = out_port0;
        case (sel)
            2'd1:    port_val = out_port1;
            2'd2:    port_val = out_port2;
            default: port_val = out_port0;
        endcase
    end

    // Full 32-bit unsigned compare so large values never alias into the low 7 bits
    assign saturate = (port_val > 32'(MAX_VAL));
    assign load_val = saturate ? 7'(MAX_VAL) : port_val[6:0];

    bcd_div10_iter u_div (
        .clock    (clock),
        .reset    (reset),
        .load     (state == LOAD),
        .step     (state == SUB),
        .load_val (load_val),
        .tens     (tens),
        .units    (units),
        .ge_radix (ge_radix)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 2'd0;
            gap_cnt    <= '0;
            ovf_next   <= 1'b0;
            dig0_hi    <= '0;
            dig0_lo    <= '0;
            dig1_hi    <= '0;
            dig1_lo    <= '0;
            dig2_hi    <= '0;
            dig2_lo    <= '0;
            ovf        <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (!hold) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    ovf_next <= saturate;
                    state    <= SUB;
                end
                SUB: begin
                    if (!ge_radix) begin
                        state <= STORE;
                    end
                end
                STORE: begin
                    case (sel)
                        2'd0: begin
                            dig0_hi <= tens;
                            dig0_lo <= units;
                            ovf[0]  <= ovf_next;
                        end
                        2'd1: begin
                            dig1_hi <= tens;
                            dig1_lo <= units;
                            ovf[1]  <= ovf_next;
                        end
                        2'd2: begin
                            dig2_hi <= tens;
                            dig2_lo <= units;
                            ovf[2]  <= ovf_next;
                        end
                        default: ;
                    endcase
                    // Port 2 closes the frame; hold is only honoured between ports 0/1 and their successor
                    if (sel == 2'd2) begin
                        sel        <= 2'd0;
                        frame_done <= 1'b1;
                        gap_cnt    <= GAP_W'(FRAME_GAP);
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        sel <= sel + 2'd1;
                        if (!hold) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_sequencer.sv
// Directed checks of the BCD sequencer: digit values, saturation, timing, hold, frame gap and reset.
module tb_display_bcd_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic [31:0] out_port0, out_port1, out_port2;

    logic [3:0]  dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo;
    logic [2:0]  ovf;
    logic        frame_done, busy;

    logic [3:0]  g_dig0_hi, g_dig0_lo, g_dig1_hi, g_dig1_lo, g_dig2_hi, g_dig2_lo;
    logic [2:0]  g_ovf;
    logic        g_frame_done, g_busy;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    display_bcd_sequencer dut (
        .clock(clock), .reset(reset),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .hold(hold),
        .dig0_hi(dig0_hi), .dig0_lo(dig0_lo), .dig1_hi(dig1_hi), .dig1_lo(dig1_lo),
        .dig2_hi(dig2_hi), .dig2_lo(dig2_lo),
        .ovf(ovf), .frame_done(frame_done), .busy(busy)
    );

    display_bcd_sequencer #(.FRAME_GAP(4)) dut_gap (
        .clock(clock), .reset(reset),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .hold(hold),
        .dig0_hi(g_dig0_hi), .dig0_lo(g_dig0_lo), .dig1_hi(g_dig1_hi), .dig1_lo(g_dig1_lo),
        .dig2_hi(g_dig2_hi), .dig2_lo(g_dig2_lo),
        .ovf(g_ovf), .frame_done(g_frame_done), .busy(g_busy)
    );

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gap_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (g_frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hold = 1'b0;
        out_port0 = 32'd7;
        out_port1 = 32'd15;
        out_port2 = 32'd42;
        repeat (3) @(negedge clock);
        checks++;
        if ({dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h0)
            $display("[TB] FAIL reset_digits: got %h want 000000", {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo});
        else passes++;
        checks++;
        if ({ovf, frame_done, busy, g_busy} !== 6'b0)
            $display("[TB] FAIL reset_flags: got ovf=%b fd=%b busy=%b gbusy=%b want all 0", ovf, frame_done, busy, g_busy);
        else passes++;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL reset_first_load: busy got %b want 1", busy);
        else passes++;
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        wait_done(100, ok);
        checks++;
        if (!ok) $display("[TB] FAIL basic_timeout: frame_done got 0 want 1");
        else passes++;
        checks++;
        if ({dig0_hi, dig0_lo} !== 8'h07) $display("[TB] FAIL basic_dig0: got %0d/%0d want 0/7", dig0_hi, dig0_lo);
        else passes++;
        checks++;
        if ({dig1_hi, dig1_lo} !== 8'h15) $display("[TB] FAIL basic_dig1: got %0d/%0d want 1/5", dig1_hi, dig1_lo);
        else passes++;
        checks++;
        if ({dig2_hi, dig2_lo} !== 8'h42) $display("[TB] FAIL basic_dig2: got %0d/%0d want 4/2", dig2_hi, dig2_lo);
        else passes++;
        checks++;
        if (ovf !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL basic_flags: got ovf=%b busy=%b want 000/0", ovf, busy);
        else passes++;
        // 9 + (0+1+4) + 1 idle cycle between consecutive frame_done pulses
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 60);
        checks++;
        if (n != 15) $display("[TB] FAIL basic_frame_period: got %0d want 15", n);
        else passes++;
    endtask

    task automatic test_max_latency();
        bit ok;
        int n;
        out_port0 = 32'd7;
        out_port1 = 32'd23;
        out_port2 = 32'd99;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(dig1_hi == 4'd2 && dig1_lo == 4'd3) && n < 100);
        checks++;
        if (n >= 100) $display("[TB] FAIL latency_dig1_timeout: dig1 got %0d/%0d want 2/3", dig1_hi, dig1_lo);
        else passes++;
        // dig1 becomes visible in the cycle port 2 is in LOAD
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(dig2_hi == 4'd9 && dig2_lo == 4'd9) && n < 40);
        checks++;
        if (n != 12) $display("[TB] FAIL latency_port2_99: got %0d cycles want 12", n);
        else passes++;
        checks++;
        if (frame_done !== 1'b1 || ovf[2] !== 1'b0)
            $display("[TB] FAIL latency_store_flags: got fd=%b ovf2=%b want 1/0", frame_done, ovf[2]);
        else passes++;
        ok = 1'b1;
    endtask

    task automatic test_saturation();
        bit ok;
        out_port0 = 32'hFFFF_FFFF;
        out_port1 = 32'd100;
        out_port2 = 32'h0000_0080;
        wait_done(100, ok);
        checks++;
        if (!ok) $display("[TB] FAIL sat_timeout: frame_done got 0 want 1");
        else passes++;
        checks++;
        if ({dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h999999)
            $display("[TB] FAIL sat_digits: got %h want 999999", {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo});
        else passes++;
        checks++;
        if (ovf !== 3'b111) $display("[TB] FAIL sat_ovf: got %b want 111", ovf);
        else passes++;
        out_port0 = 32'd5;
        out_port1 = 32'd99;
        out_port2 = 32'd10;
        wait_done(100, ok);
        checks++;
        if (!ok) $display("[TB] FAIL unsat_timeout: frame_done got 0 want 1");
        else passes++;
        checks++;
        if ({dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h059910)
            $display("[TB] FAIL unsat_digits: got %h want 059910", {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo});
        else passes++;
        checks++;
        if (ovf !== 3'b000) $display("[TB] FAIL unsat_ovf: got %b want 000", ovf);
        else passes++;
    endtask

    task automatic test_port_change();
        bit ok;
        out_port0 = 32'd0;
        out_port1 = 32'd30;
        out_port2 = 32'd0;
        // port 1 LOADs four cycles after the frame_done cycle
        repeat (5) @(negedge clock);
        out_port1 = 32'd61;
        wait_done(100, ok);
        checks++;
        if (!ok || {dig1_hi, dig1_lo} !== 8'h30)
            $display("[TB] FAIL change_inflight: got ok=%b dig1=%0d/%0d want 3/0", ok, dig1_hi, dig1_lo);
        else passes++;
        wait_done(100, ok);
        checks++;
        if (!ok || {dig1_hi, dig1_lo} !== 8'h61)
            $display("[TB] FAIL change_next_frame: got ok=%b dig1=%0d/%0d want 6/1", ok, dig1_hi, dig1_lo);
        else passes++;
    endtask

    task automatic test_hold();
        bit stable;
        out_port0 = 32'd0;
        out_port1 = 32'd50;
        out_port2 = 32'd7;
        repeat (6) @(negedge clock);
        hold = 1'b1;
        repeat (6) @(negedge clock);
        checks++;
        if ({dig1_hi, dig1_lo} !== 8'h50 || busy !== 1'b0)
            $display("[TB] FAIL hold_port1_done: got dig1=%0d/%0d busy=%b want 5/0 busy=0", dig1_hi, dig1_lo, busy);
        else passes++;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if ({dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h005000 ||
                ovf !== 3'b000 || busy !== 1'b0 || frame_done !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) $display("[TB] FAIL hold_stable: got unstable outputs want digits 005000 and idle");
        else passes++;
        hold = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL hold_release_load: busy got %b want 1", busy);
        else passes++;
        repeat (3) @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || {dig2_hi, dig2_lo} !== 8'h07)
            $display("[TB] FAIL hold_resume_port2: got fd=%b dig2=%0d/%0d want 1 0/7", frame_done, dig2_hi, dig2_lo);
        else passes++;
    endtask

    task automatic test_frame_gap();
        bit ok;
        int n;
        out_port0 = 32'd37;
        out_port1 = 32'd58;
        out_port2 = 32'd81;
        wait_gap_done(200, ok);
        wait_gap_done(200, ok);
        checks++;
        if (!ok) $display("[TB] FAIL gap_timeout: frame_done got 0 want 1");
        else passes++;
        checks++;
        if ({g_dig0_hi, g_dig0_lo, g_dig1_hi, g_dig1_lo, g_dig2_hi, g_dig2_lo} !== 24'h375881 || g_ovf !== 3'b000)
            $display("[TB] FAIL gap_digits: got %h ovf=%b want 375881 000",
                     {g_dig0_hi, g_dig0_lo, g_dig1_hi, g_dig1_lo, g_dig2_hi, g_dig2_lo}, g_ovf);
        else passes++;
        checks++;
        if (g_busy !== 1'b0) $display("[TB] FAIL gap_done_idle: busy got %b want 0", g_busy);
        else passes++;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (g_busy) break;
            n++;
        end
        checks++;
        if (n != 4) $display("[TB] FAIL gap_idle_cycles: got %0d want 4", n);
        else passes++;
    endtask

    task automatic test_reset_mid_sub();
        bit ok;
        wait_done(100, ok);
        checks++;
        if (!ok || {dig0_hi, dig0_lo} !== 8'h37)
            $display("[TB] FAIL midreset_pre: got ok=%b dig0=%0d/%0d want 3/7", ok, dig0_hi, dig0_lo);
        else passes++;
        // port 0 (tens=3) is in SUB from two to five cycles after frame_done
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h0 || ovf !== 3'b000 || busy !== 1'b0)
            $display("[TB] FAIL midreset_clear: got %h ovf=%b busy=%b want 000000 000 0",
                     {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo}, ovf, busy);
        else passes++;
        reset = 1'b0;
        wait_done(100, ok);
        checks++;
        if (!ok || {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo} !== 24'h375881)
            $display("[TB] FAIL midreset_restart: got ok=%b digits=%h want 375881",
                     ok, {dig0_hi, dig0_lo, dig1_hi, dig1_lo, dig2_hi, dig2_lo});
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_latency();
        test_saturation();
        test_port_change();
        test_hold();
        test_frame_gap();
        test_reset_mid_sub();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
